// File: rtl/core_axi_rd_arbiter.sv
// ---------------------------------------------------------------------------
// core_axi_rd_arbiter
//
// Purpose: shares one AXI-lite read port to memory between the fetch stage
// (if_*) and the load/store unit (ls_*). One transaction is in flight at a
// time; the controller walks IDLE -> ADDR -> DATA -> IDLE.
//
// Optional feature: define ARB_ROUND_ROBIN_EN for round-robin tie breaking.
// Without it, load/store always wins when both masters request together.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   if_AR* / if_R*           fetch-stage read address / read data channels
//   ls_AR* / ls_R*           load/store read address / read data channels
//   AR* / R*                 shared read channels towards memory
//   grant                    current owner (0 = fetch, 1 = load/store),
//                            meaningful only while a transaction is open
// ---------------------------------------------------------------------------
package core_pkg;
  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
endpackage

module core_axi_rd_arbiter #(
  parameter int ADDR_WIDTH = core_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = core_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  // fetch stage
  input  logic [ADDR_WIDTH-1:0] if_ARADDR,
  input  logic                  if_ARVALID,
  output logic                  if_ARREADY,
  output logic [DATA_WIDTH-1:0] if_RDATA,
  output logic                  if_RVALID,
  input  logic                  if_RREADY,
  // load/store unit
  input  logic [ADDR_WIDTH-1:0] ls_ARADDR,
  input  logic                  ls_ARVALID,
  output logic                  ls_ARREADY,
  output logic [DATA_WIDTH-1:0] ls_RDATA,
  output logic                  ls_RVALID,
  input  logic                  ls_RREADY,
  // shared memory port
  output logic [ADDR_WIDTH-1:0] ARADDR,
  output logic                  ARVALID,
  input  logic                  ARREADY,
  input  logic [DATA_WIDTH-1:0] RDATA,
  input  logic                  RVALID,
  output logic                  RREADY,
  // ownership
  output logic                  grant
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_grant;

  logic w_any_req;
  logic w_win;        // 1 = load/store wins this arbitration
  logic w_accept;
  logic w_in_data;
  logic w_sel_rready;

  assign w_any_req = if_ARVALID | ls_ARVALID;

`ifdef ARB_ROUND_ROBIN_EN
  // Remembers who was granted last; reset value means "fetch last", so
  // load/store takes the first tie after reset.
  logic r_last;

  assign w_win = (if_ARVALID & ls_ARVALID) ? ~r_last : ls_ARVALID;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last <= 1'b0;
    end else if (w_accept) begin
      r_last <= w_win;
    end
  end
`else
  // Fixed priority: load/store wins any tie.
  assign w_win = ls_ARVALID;
`endif

  // NOTE: ARREADY towards the masters is combinational, so it is gated with
  // rst explicitly; register-driven outputs already clear on reset.
  assign w_accept   = rst & (r_state == ST_IDLE) & w_any_req;
  assign if_ARREADY = w_accept & ~w_win;
  assign ls_ARREADY = w_accept &  w_win;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_grant <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_addr  <= w_win ? ls_ARADDR : if_ARADDR;
            r_grant <= w_win;
            r_state <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (ARREADY) r_state <= ST_DATA;
        end
        ST_DATA: begin
          if (RVALID && w_sel_rready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_in_data    = (r_state == ST_DATA);
  assign w_sel_rready = r_grant ? ls_RREADY : if_RREADY;

  assign ARADDR  = r_addr;
  assign ARVALID = (r_state == ST_ADDR);
  assign RREADY  = w_in_data & w_sel_rready;

  // Responses reach only the owner, and only while a response is expected.
  assign if_RVALID = w_in_data & ~r_grant & RVALID;
  assign ls_RVALID = w_in_data &  r_grant & RVALID;

  // Data is broadcast; the valids decide who consumes it.
  assign if_RDATA = RDATA;
  assign ls_RDATA = RDATA;

  assign grant = r_grant;

endmodule

// File: tb/tb_core_axi_rd_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for core_axi_rd_arbiter: a directed cycle table, hand-written
// reset/tie sequences, and a randomized run against a transaction-level
// model of the two masters and the memory.
// ---------------------------------------------------------------------------
module tb_core_axi_rd_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_ARADDR, ls_ARADDR, ARADDR;
  logic        if_ARVALID, if_ARREADY, ls_ARVALID, ls_ARREADY;
  logic [31:0] if_RDATA, ls_RDATA, RDATA;
  logic        if_RVALID, if_RREADY, ls_RVALID, ls_RREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY, grant;

  always #5 clk = ~clk;

  core_axi_rd_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .if_ARADDR(if_ARADDR), .if_ARVALID(if_ARVALID), .if_ARREADY(if_ARREADY),
    .if_RDATA(if_RDATA), .if_RVALID(if_RVALID), .if_RREADY(if_RREADY),
    .ls_ARADDR(ls_ARADDR), .ls_ARVALID(ls_ARVALID), .ls_ARREADY(ls_ARREADY),
    .ls_RDATA(ls_RDATA), .ls_RVALID(ls_RVALID), .ls_RREADY(ls_RREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RVALID(RVALID), .RREADY(RREADY),
    .grant(grant)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic iv, input logic [31:0] ia, input logic lv, input logic [31:0] la,
                       input logic ardy, input logic rv, input logic [31:0] rd,
                       input logic irr, input logic lrr);
    if_ARVALID = iv; if_ARADDR = ia; ls_ARVALID = lv; ls_ARADDR = la;
    ARREADY = ardy; RVALID = rv; RDATA = rd; if_RREADY = irr; ls_RREADY = lrr;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Memory contents seen by the random run: any fixed function of address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_F00D;
  endfunction

  // Directed per-cycle vectors: stimulus, then expected outputs.
  typedef struct {
    logic        if_v;  logic [31:0] if_a;
    logic        ls_v;  logic [31:0] ls_a;
    logic        ardy;  logic        rv;    logic [31:0] rdata;
    logic        if_rr; logic        ls_rr;
    logic        e_if_ardy, e_ls_ardy, e_arv;
    logic [31:0] e_araddr;
    logic        e_rrdy, e_if_rv, e_ls_rv;
    logic        chk_gnt, e_gnt;
  } vec_t;

  localparam logic T = 1'b1;
  localparam logic F = 1'b0;
  localparam logic [31:0] BEEF = 32'hDEAD_BEEF;
  localparam logic [31:0] LSA  = 32'h8000_0000;

  vec_t vecs[$];

  // Tie-sequence expectation: round robin alternates starting with ls.
  task automatic tie_txn(input logic exp_win, input int k);
    @(negedge clk);
    drive(1'b1, 32'h0000_0200, 1'b1, LSA, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    #1;
    check_bit($sformatf("tie%0d if_ARREADY", k), if_ARREADY, ~exp_win);
    check_bit($sformatf("tie%0d ls_ARREADY", k), ls_ARREADY, exp_win);
    @(negedge clk);
    #1;
    check_bit($sformatf("tie%0d grant", k), grant, exp_win);
    check_word($sformatf("tie%0d ARADDR", k), ARADDR, exp_win ? LSA : 32'h0000_0200);
    @(negedge clk);
    RVALID = 1'b1;
    RDATA  = 32'hA000_0000 | 32'(k);
    #1;
    check_bit($sformatf("tie%0d if_RVALID", k), if_RVALID, ~exp_win);
    check_bit($sformatf("tie%0d ls_RVALID", k), ls_RVALID, exp_win);
  endtask

  // Random-run model state (transaction level).
  logic        req_v [2];
  logic [31:0] req_a [2];
  logic        m_out, m_sent, m_owner, m_last;
  logic [31:0] m_addr;
  int          n_done;

  initial begin
    // ---------------- reset values ----------------
    rst = 1'b0;
    drive(1'b1, 32'h1234, 1'b1, 32'h5678, 1'b1, 1'b1, 32'h9, 1'b1, 1'b1);
    #2;
    check_bit("rst if_ARREADY", if_ARREADY, 1'b0);
    check_bit("rst ls_ARREADY", ls_ARREADY, 1'b0);
    check_bit("rst ARVALID", ARVALID, 1'b0);
    check_bit("rst RREADY", RREADY, 1'b0);
    check_bit("rst if_RVALID", if_RVALID, 1'b0);
    check_bit("rst ls_RVALID", ls_RVALID, 1'b0);
    check_bit("rst grant", grant, 1'b0);
    check_word("rst ARADDR", ARADDR, 32'h0);
    do_reset();

    // ---------------- directed table ----------------
    //                 if_v if_a           ls_v ls_a ardy rv rdata          irr lrr | eia ela earv earaddr        errdy eirv elrv cg eg
    vecs.push_back('{T, 32'h100, F, 32'h0, T, T, BEEF,          T, T,  T, F, F, 32'h0,   F, F, F, F, F}); // fetch accepted
    vecs.push_back('{F, 32'h100, F, 32'h0, T, T, BEEF,          T, T,  F, F, T, 32'h100, F, F, F, T, F}); // ADDR, RVALID ignored
    vecs.push_back('{F, 32'h0,   F, 32'h0, T, T, BEEF,          T, T,  F, F, F, 32'h0,   T, T, F, T, F}); // DATA delivered
    vecs.push_back('{T, 32'h200, T, LSA,   F, T, 32'h1111_1111, T, T,  F, T, F, 32'h0,   F, F, F, F, F}); // tie -> ls
    vecs.push_back('{T, 32'h200, F, 32'h0, F, T, 32'h1111_1111, T, T,  F, F, T, LSA,     F, F, F, T, T}); // ADDR stall 1
    vecs.push_back('{T, 32'h200, F, 32'h0, F, T, 32'h1111_1111, T, T,  F, F, T, LSA,     F, F, F, T, T}); // stall 2
    vecs.push_back('{T, 32'h200, F, 32'h0, F, T, 32'h1111_1111, T, T,  F, F, T, LSA,     F, F, F, T, T}); // stall 3
    vecs.push_back('{T, 32'h200, F, 32'h0, F, T, 32'h1111_1111, T, T,  F, F, T, LSA,     F, F, F, T, T}); // stall 4
    vecs.push_back('{T, 32'h200, F, 32'h0, T, T, 32'h1111_1111, T, T,  F, F, T, LSA,     F, F, F, T, T}); // ARREADY
    vecs.push_back('{T, 32'h200, F, 32'h0, F, T, 32'h2222_2222, T, F,  F, F, F, 32'h0,   F, F, T, T, T}); // DATA, ls not ready
    vecs.push_back('{T, 32'h200, F, 32'h0, F, T, 32'h2222_2222, T, F,  F, F, F, 32'h0,   F, F, T, T, T}); // still waiting
    vecs.push_back('{T, 32'h200, F, 32'h0, F, T, 32'h2222_2222, T, T,  F, F, F, 32'h0,   T, F, T, T, T}); // ls takes it
    vecs.push_back('{T, 32'h200, F, 32'h0, T, F, 32'h0,         T, T,  T, F, F, 32'h0,   F, F, F, F, F}); // fetch next
    vecs.push_back('{F, 32'h0,   F, 32'h0, T, F, 32'h0,         T, T,  F, F, T, 32'h200, F, F, F, T, F}); // single ADDR cycle
    vecs.push_back('{F, 32'h0,   F, 32'h0, F, F, 32'h0,         T, T,  F, F, F, 32'h0,   T, F, F, T, F}); // DATA, no RVALID
    vecs.push_back('{F, 32'h0,   F, 32'h0, F, T, 32'h3333_3333, T, T,  F, F, F, 32'h0,   T, T, F, T, F}); // delivered
    vecs.push_back('{F, 32'h0,   F, 32'h0, T, T, 32'h4444_4444, T, T,  F, F, F, 32'h0,   F, F, F, F, F}); // idle, stray RVALID

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].if_v, vecs[i].if_a, vecs[i].ls_v, vecs[i].ls_a, vecs[i].ardy,
            vecs[i].rv, vecs[i].rdata, vecs[i].if_rr, vecs[i].ls_rr);
      #1;
      check_bit($sformatf("v%0d if_ARREADY", i), if_ARREADY, vecs[i].e_if_ardy);
      check_bit($sformatf("v%0d ls_ARREADY", i), ls_ARREADY, vecs[i].e_ls_ardy);
      check_bit($sformatf("v%0d ARVALID", i), ARVALID, vecs[i].e_arv);
      if (vecs[i].e_arv) check_word($sformatf("v%0d ARADDR", i), ARADDR, vecs[i].e_araddr);
      check_bit($sformatf("v%0d RREADY", i), RREADY, vecs[i].e_rrdy);
      check_bit($sformatf("v%0d if_RVALID", i), if_RVALID, vecs[i].e_if_rv);
      check_bit($sformatf("v%0d ls_RVALID", i), ls_RVALID, vecs[i].e_ls_rv);
      check_word($sformatf("v%0d if_RDATA", i), if_RDATA, vecs[i].rdata);
      check_word($sformatf("v%0d ls_RDATA", i), ls_RDATA, vecs[i].rdata);
      if (vecs[i].chk_gnt) check_bit($sformatf("v%0d grant", i), grant, vecs[i].e_gnt);
    end

    // ---------------- reset in the middle of DATA ----------------
    @(negedge clk);
    drive(1'b1, 32'h500, 1'b0, 32'h0, 1'b1, 1'b1, 32'hBAD0_BAD0, 1'b0, 1'b0);
    @(negedge clk);
    if_ARVALID = 1'b0;
    @(negedge clk);
    #1;
    check_bit("mid if_RVALID before rst", if_RVALID, 1'b1);
    rst = 1'b0;
    if_ARVALID = 1'b1;
    #1;
    check_bit("mid rst ARVALID", ARVALID, 1'b0);
    check_bit("mid rst RREADY", RREADY, 1'b0);
    check_bit("mid rst if_RVALID", if_RVALID, 1'b0);
    check_bit("mid rst ls_RVALID", ls_RVALID, 1'b0);
    check_bit("mid rst if_ARREADY", if_ARREADY, 1'b0);
    check_bit("mid rst grant", grant, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 32'h300, 1'b0, 32'h0, 1'b0, 1'b1, 32'hBAD0_BAD0, 1'b1, 1'b1);
    #1;
    check_bit("post rst if_ARREADY", if_ARREADY, 1'b1);
    check_bit("post rst stale if_RVALID", if_RVALID, 1'b0);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hBAD0_BAD0, 1'b1, 1'b1);
    #1;
    check_bit("post rst ARVALID", ARVALID, 1'b1);
    check_word("post rst ARADDR", ARADDR, 32'h300);
    check_bit("post rst ADDR if_RVALID", if_RVALID, 1'b0);
    @(negedge clk);
    RDATA = 32'h3030_3030;
    #1;
    check_bit("post rst DATA if_RVALID", if_RVALID, 1'b1);
    check_bit("post rst DATA RREADY", RREADY, 1'b1);
    check_word("post rst if_RDATA", if_RDATA, 32'h3030_3030);
    @(negedge clk);
    RDATA = 32'hBAD0_BAD0;
    #1;
    check_bit("post rst idle if_RVALID", if_RVALID, 1'b0);

    // ---------------- repeated ties ----------------
    do_reset();
    begin
      logic last_w, win_w;
      last_w = 1'b0;
      for (int k = 0; k < 4; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
        win_w = ~last_w;
`else
        win_w = 1'b1;
`endif
        tie_txn(win_w, k);
        last_w = win_w;
      end
    end

    // ---------------- randomized run ----------------
    do_reset();
    req_v[0] = 1'b0; req_v[1] = 1'b0; req_a[0] = '0; req_a[1] = '0;
    m_out = 1'b0; m_sent = 1'b0; m_owner = 1'b0; m_last = 1'b0; m_addr = '0;
    n_done = 0;
    for (int c = 0; c < 3000; c++) begin
      logic win_valid, win, ardy, rv, irr, lrr, owner_rr;
      logic [31:0] rd;
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
        if (!req_v[m] && $urandom_range(0, 3) == 0) begin
          req_v[m] = 1'b1;
          req_a[m] = $urandom;
        end
      end
      ardy = ($urandom_range(0, 1) == 1);
      irr  = ($urandom_range(0, 3) != 0);
      lrr  = ($urandom_range(0, 3) != 0);
      if (m_out && m_sent) begin
        rv = ($urandom_range(0, 2) != 0);
        rd = mem_word(m_addr);
      end else begin
        rv = ($urandom_range(0, 1) == 1);
        rd = $urandom;
      end
      drive(req_v[0], req_a[0], req_v[1], req_a[1], ardy, rv, rd, irr, lrr);

      win_valid = !m_out && (req_v[0] || req_v[1]);
`ifdef ARB_ROUND_ROBIN_EN
      win = (req_v[0] && req_v[1]) ? ~m_last : req_v[1];
`else
      win = req_v[1];
`endif
      owner_rr = m_owner ? lrr : irr;
      #1;
      check_bit("rnd if_ARREADY", if_ARREADY, win_valid && !win);
      check_bit("rnd ls_ARREADY", ls_ARREADY, win_valid && win);
      check_bit("rnd ARVALID", ARVALID, m_out && !m_sent);
      check_bit("rnd RREADY", RREADY, m_out && m_sent && owner_rr);
      check_bit("rnd if_RVALID", if_RVALID, m_out && m_sent && !m_owner && rv);
      check_bit("rnd ls_RVALID", ls_RVALID, m_out && m_sent && m_owner && rv);
      if (m_out) check_bit("rnd grant", grant, m_owner);
      if (m_out && !m_sent) check_word("rnd ARADDR", ARADDR, m_addr);
      if (m_out && m_sent && rv)
        check_word("rnd data", m_owner ? ls_RDATA : if_RDATA, mem_word(m_addr));

      if (win_valid) begin
        m_out = 1'b1; m_sent = 1'b0; m_owner = win; m_addr = req_a[win];
        m_last = win; req_v[win] = 1'b0;
      end else if (m_out && !m_sent) begin
        if (ardy) m_sent = 1'b1;
      end else if (m_out && m_sent && rv && owner_rr) begin
        m_out = 1'b0;
        n_done++;
      end
    end
    check_bit("rnd enough transactions", n_done > 100, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
